video_mode_ctrl: RTL and testbench

Frame-synchronous controller for the RGB / gray / binary display datapath. It debounces the three user keys and turns them into one-cycle press events. From those events it maintains pending display-mode, threshold and auto-threshold settings, and commits them to its outputs only at frame start, so a setting never changes mid-frame. In auto mode it accumulates frame luma and computes the mean with a sequential divider during vertical blanking; that mean becomes the binarisation threshold.

---
 rtl/video_mode_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_video_mode_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl
// Frame-synchronous control for the RGB / gray / binary display datapath.
// Debounces three user keys into press events, keeps pending mode/threshold/auto
// settings and commits them only at frame start (rising edge of i_vs). In auto
// mode the previous frame's mean luma, computed by a serial restoring divider
// during vertical blanking, becomes the binarisation threshold.
//
// Ports
//   clk        system/pixel clock, rising edge
//   rst        asynchronous active-high reset
//   key[2:0]   raw active-high keys: [0] cycle mode, [1] threshold += step, [2] toggle auto
//   i_vs       vertical sync, rising edge = frame start
//   i_de       active-pixel strobe
//   i_gray     pixel luma, valid with i_de
//   mode       committed mode: 0 RGB, 1 gray, 2 binary
//   threshold  committed binarisation threshold
//   auto_en    committed auto-threshold enable
//   div_busy   mean divider running
//   th_upd     one-cycle pulse when an auto threshold is written
module video_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [7:0]  TH_RESET        = 8'd40,
    parameter logic [7:0]  TH_STEP         = 8'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key,
    input  logic       i_vs,
    input  logic       i_de,
    input  logic [7:0] i_gray,
    output logic [1:0] mode,
    output logic [7:0] threshold,
    output logic       auto_en,
    output logic       div_busy,
    output logic       th_upd
);

    localparam int unsigned    DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    // ---------------- key synchronise + debounce ----------------
    logic [2:0] key_evt;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key
            logic [1:0]      sync_q;
            logic            level_q;
            logic [DB_W-1:0] cnt_q;
            logic            press_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q  <= '0;
                    level_q <= 1'b0;
                    cnt_q   <= '0;
                    press_q <= 1'b0;
                end else begin
                    sync_q  <= {sync_q[0], key[gi]};
                    press_q <= 1'b0;
                    if (sync_q[1] == level_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        level_q <= sync_q[1];
                        cnt_q   <= '0;
                        press_q <= sync_q[1];   // only 0->1 yields an event
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end

            assign key_evt[gi] = press_q;
        end
    endgenerate

    // ---------------- frame start ----------------
    logic vs_q, vs_d_q;
    logic vs_rise;
    assign vs_rise = vs_q & ~vs_d_q;

    // ---------------- pending settings ----------------
    logic [1:0] mode_p_q;
    logic [7:0] th_p_q;
    logic       auto_p_q;
    logic [8:0] th_sum;
    logic [7:0] th_step_sat;

    assign th_sum      = {1'b0, th_p_q} + {1'b0, TH_STEP};
    assign th_step_sat = th_sum[8] ? 8'hFF : th_sum[7:0];

    // ---------------- accumulator ----------------
    logic [31:0] sum_q, snap_sum_q;
    logic [23:0] cnt_q, snap_cnt_q;
    logic        start_q;           // division request, one cycle after vs_rise
    logic [32:0] sum_add;
    assign sum_add = {1'b0, sum_q} + {25'd0, i_gray};

    // ---------------- divider ----------------
    state_t      state_q, state_d;
    logic [23:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;      // dividend shifts out the top, quotient in the bottom
    logic [23:0] dvs_q, dvs_d;
    logic [4:0]  bit_q, bit_d;
    logic        done_wr;
    logic [24:0] rem_shift;
    logic [23:0] rem_sub;
    logic        rem_ge;
    logic [7:0]  quo_clamp;

    assign rem_shift = {rem_q, quo_q[31]};
    assign rem_ge    = (rem_shift >= {1'b0, dvs_q});
    // When rem_ge holds the difference is below the divisor, so 24 bits suffice.
    assign rem_sub   = rem_shift[23:0] - dvs_q;
    assign quo_clamp = (|quo_q[31:8]) ? 8'hFF : quo_q[7:0];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        bit_d   = bit_q;
        done_wr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_q && (snap_cnt_q != 24'd0)) begin
                    state_d = S_DIV;
                    rem_d   = '0;
                    quo_d   = snap_sum_q;
                    dvs_d   = snap_cnt_q;
                    bit_d   = '0;
                end
            end
            S_DIV: begin
                rem_d = rem_ge ? rem_sub : rem_shift[23:0];
                quo_d = {quo_q[30:0], rem_ge};
                bit_d = bit_q + 5'd1;
                if (bit_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_wr = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // A new frame aborts any running division; the fresh snapshot restarts it
        // via start_q on the following cycle.
        if (vs_rise) begin
            state_d = S_IDLE;
            done_wr = 1'b0;
        end
    end

    // ---------------- committed outputs ----------------
    logic [1:0] mode_q;
    logic [7:0] threshold_q;
    logic       auto_en_q, div_busy_q, th_upd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q        <= 1'b0;
            vs_d_q      <= 1'b0;
            mode_p_q    <= 2'd0;
            th_p_q      <= TH_RESET;
            auto_p_q    <= 1'b0;
            sum_q       <= '0;
            cnt_q       <= '0;
            snap_sum_q  <= '0;
            snap_cnt_q  <= '0;
            start_q     <= 1'b0;
            state_q     <= S_IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            bit_q       <= '0;
            mode_q      <= 2'd0;
            threshold_q <= TH_RESET;
            auto_en_q   <= 1'b0;
            div_busy_q  <= 1'b0;
            th_upd_q    <= 1'b0;
        end else begin
            vs_q   <= i_vs;
            vs_d_q <= vs_q;

            if (key_evt[0]) mode_p_q <= (mode_p_q == 2'd2) ? 2'd0 : mode_p_q + 2'd1;
            if (key_evt[1] && !auto_p_q) th_p_q <= th_step_sat;
            if (key_evt[2]) auto_p_q <= ~auto_p_q;

            start_q <= 1'b0;
            if (vs_rise) begin
                snap_sum_q <= sum_q;
                snap_cnt_q <= cnt_q;
                sum_q      <= '0;
                cnt_q      <= '0;
                start_q    <= auto_p_q;
            end else if (i_de) begin
                sum_q <= sum_add[32] ? 32'hFFFF_FFFF : sum_add[31:0];
                cnt_q <= (&cnt_q) ? cnt_q : cnt_q + 24'd1;
            end

            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            bit_q   <= bit_d;

            // Commit uses the pre-event pending values (non-blocking update above).
            if (vs_rise) begin
                mode_q    <= mode_p_q;
                auto_en_q <= auto_p_q;
                if (!auto_p_q) threshold_q <= th_p_q;
            end else if (done_wr && auto_en_q) begin
                threshold_q <= quo_clamp;
            end
            th_upd_q   <= done_wr & auto_en_q;
            div_busy_q <= (state_d == S_DIV);
        end
    end

    assign mode      = mode_q;
    assign threshold = threshold_q;
    assign auto_en   = auto_en_q;
    assign div_busy  = div_busy_q;
    assign th_upd    = th_upd_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
module tb_video_mode_ctrl;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] key = 3'b000;
    logic       i_vs = 1'b0;
    logic       i_de = 1'b0;
    logic [7:0] i_gray = 8'd0;
    logic [1:0] mode;
    logic [7:0] threshold;
    logic       auto_en, div_busy, th_upd;

    always #5 clk = ~clk;

    video_mode_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TH_RESET(8'd40),
        .TH_STEP(8'd5)
    ) dut (
        .clk(clk), .rst(rst), .key(key), .i_vs(i_vs), .i_de(i_de), .i_gray(i_gray),
        .mode(mode), .threshold(threshold), .auto_en(auto_en),
        .div_busy(div_busy), .th_upd(th_upd)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int upd_seen = 0;

    // Reference model: pending settings, committed settings, frame statistics.
    int     p_mode = 0, p_th = 40, p_auto = 0;
    int     m_mode = 0, m_thr = 40, m_auto = 0;
    longint acc_sum = 0, acc_cnt = 0;
    int     exp_cyc = -1, exp_val = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock; watches th_upd against the expected auto-update cycle.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (th_upd === 1'b1) upd_seen++;
        if (cyc == exp_cyc) begin
            if (m_auto != 0) begin
                check("th_upd_pulse", 32'(th_upd), 32'd1);
                check("auto_threshold", 32'(threshold), 32'(exp_val));
                m_thr = exp_val;
            end else begin
                check("th_upd_auto_off", 32'(th_upd), 32'd0);
            end
            exp_cyc = -1;
        end else if (th_upd !== 1'b0) begin
            check("th_upd_unexpected", 32'(th_upd), 32'd0);
        end
    endtask

    task automatic model_reset();
        p_mode = 0; p_th = 40; p_auto = 0;
        m_mode = 0; m_thr = 40; m_auto = 0;
        acc_sum = 0; acc_cnt = 0; exp_cyc = -1;
    endtask

    task automatic press(input logic [2:0] mask);
        int old_auto;
        key = mask;
        repeat (8) tick();
        key = 3'b000;
        repeat (8) tick();
        old_auto = p_auto;
        if (mask[0]) p_mode = (p_mode + 1) % 3;
        if (mask[1] && old_auto == 0) p_th = (p_th + 5 > 255) ? 255 : p_th + 5;
        if (mask[2]) p_auto = (p_auto == 0) ? 1 : 0;
        $display("press mask=%b -> pending mode=%0d th=%0d auto=%0d", mask, p_mode, p_th, p_auto);
    endtask

    task automatic pixels(input int n, input bit rnd, input int val);
        for (int i = 0; i < n; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                i_de = 1'b0;
                tick();
            end
            i_de   = 1'b1;
            i_gray = rnd ? 8'($urandom_range(0, 255)) : 8'(val);
            acc_sum += longint'(i_gray);
            acc_cnt++;
            tick();
        end
        i_de = 1'b0;
    endtask

    task automatic vs_edge();
        bit dividing;
        longint q;
        i_de = 1'b0;
        i_vs = 1'b1;
        tick();
        tick();
        m_mode = p_mode;
        m_auto = p_auto;
        if (p_auto == 0) m_thr = p_th;
        dividing = (p_auto != 0) && (acc_cnt > 0);
        if (dividing) begin
            q = acc_sum / acc_cnt;
            exp_val = (q > 255) ? 255 : int'(q);
            exp_cyc = cyc + 34;
        end else begin
            exp_cyc = -1;
        end
        $display("frame commit: pixels=%0d sum=%0d mode=%0d thr=%0d auto=%0d expect_mean=%0d",
                 acc_cnt, acc_sum, m_mode, m_thr, m_auto, dividing ? exp_val : -1);
        acc_sum = 0;
        acc_cnt = 0;
        check("mode_commit", 32'(mode), 32'(m_mode));
        check("auto_en_commit", 32'(auto_en), 32'(m_auto));
        check("threshold_commit", 32'(threshold), 32'(m_thr));
        tick();
        tick();
        check("div_busy", 32'(div_busy), 32'(dividing));
        i_vs = 1'b0;
    endtask

    initial begin
        int ca, u0;
        model_reset();
        repeat (3) tick();
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_threshold", 32'(threshold), 32'd40);
        check("rst_auto_en", 32'(auto_en), 32'd0);
        check("rst_div_busy", 32'(div_busy), 32'd0);
        check("rst_th_upd", 32'(th_upd), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Debounce: 3-cycle glitch rejected, 10-cycle hold accepted.
        key = 3'b001;
        repeat (3) tick();
        key = 3'b000;
        repeat (10) tick();
        vs_edge();
        repeat (10) tick();
        key = 3'b001;
        repeat (10) tick();
        key = 3'b000;
        repeat (8) tick();
        p_mode = 1;
        vs_edge();
        repeat (40) tick();

        // Mode wrap; mode holds between frames.
        for (int i = 0; i < 3; i++) begin
            press(3'b001);
            check("mode_hold_before_vs", 32'(mode), 32'(m_mode));
            vs_edge();
            repeat (20) tick();
            check("mode_hold_after_vs", 32'(mode), 32'(m_mode));
        end

        // Threshold saturation in manual mode.
        for (int i = 0; i < 44; i++) press(3'b010);
        check("th_pending_not_committed", 32'(threshold), 32'(m_thr));
        vs_edge();
        check("th_saturated", 32'(threshold), 32'd255);
        repeat (40) tick();

        // Auto mean: 100 x 80 + 100 x 121 -> 100.
        press(3'b100);
        vs_edge();
        repeat (40) tick();
        u0 = upd_seen;
        pixels(100, 1'b0, 80);
        pixels(100, 1'b0, 121);
        vs_edge();
        repeat (40) tick();
        check("auto_mean_100", 32'(threshold), 32'd100);
        check("auto_mean_upd_count", 32'(upd_seen - u0), 32'd1);
        u0 = upd_seen;
        vs_edge();
        repeat (40) tick();
        check("empty_frame_threshold", 32'(threshold), 32'd100);
        check("empty_frame_no_upd", 32'(upd_seen - u0), 32'd0);

        // Reset while dividing with mode=2, threshold=100.
        while (p_mode != 2) press(3'b001);
        pixels(30, 1'b0, 150);
        vs_edge();
        check("pre_reset_mode", 32'(mode), 32'd2);
        check("pre_reset_threshold", 32'(threshold), 32'd100);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("midrst_mode", 32'(mode), 32'd0);
        check("midrst_threshold", 32'(threshold), 32'd40);
        check("midrst_auto_en", 32'(auto_en), 32'd0);
        check("midrst_div_busy", 32'(div_busy), 32'd0);
        check("midrst_th_upd", 32'(th_upd), 32'd0);
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        u0 = upd_seen;
        repeat (45) tick();
        check("post_reset_no_upd", 32'(upd_seen - u0), 32'd0);
        check("post_reset_threshold", 32'(threshold), 32'd40);

        // Abort: second frame start ~10 cycles into DIV.
        press(3'b100);
        vs_edge();
        repeat (40) tick();
        pixels(20, 1'b1, 0);
        vs_edge();
        ca = exp_cyc - 34;
        u0 = upd_seen;
        for (int i = 0; i < 5; i++) begin
            i_de   = 1'b1;
            i_gray = 8'($urandom_range(0, 255));
            acc_sum += longint'(i_gray);
            acc_cnt++;
            tick();
        end
        i_de = 1'b0;
        for (int i = 0; i < 20 && cyc < ca + 10; i++) tick();
        vs_edge();
        repeat (45) tick();
        check("abort_single_upd", 32'(upd_seen - u0), 32'd1);
        check("abort_threshold", 32'(threshold), 32'(m_thr));

        // Randomised frames and key presses.
        for (int f = 0; f < 15; f++) begin
            int np;
            np = $urandom_range(0, 2);
            for (int k = 0; k < np; k++) press(3'($urandom_range(1, 7)));
            pixels($urandom_range(0, 60), 1'b1, 0);
            vs_edge();
            repeat (40) tick();
            check("rand_threshold", 32'(threshold), 32'(m_thr));
            check("rand_mode", 32'(mode), 32'(m_mode));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
